// File: rtl/prog_spi_sequencer.sv
// Purpose: mode-00 SPI master that shifts one NUM_BITS frame (LSB first) into the
//   AFE programmer, or drives a digital-reset pulse (CS=1 and SCLK=1) on the same pins.
// Latency: DONE (2*NUM_BITS+2)*HALF_DIV cycles after the accept edge for a load, RST_HOLD for a reset pulse.
// Backpressure: START/DRST_REQ are sampled only in IDLE; requests seen while BUSY are dropped, not queued.
// Ports: CLK/RST_N clock and async active-low reset; START+CFG frame load request;
//   DRST_REQ reset-pulse request (wins over START); BUSY/DONE status; SDI/SCLK/CS programmer pins.
module prog_spi_sequencer #(
  parameter int NUM_BITS = 111,
  parameter int HALF_DIV = 4,
  parameter int RST_HOLD = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [NUM_BITS-1:0] CFG,
  input  logic                DRST_REQ,
  output logic                BUSY,
  output logic                DONE,
  output logic                SDI,
  output logic                SCLK,
  output logic                CS
);

  localparam int BW   = $clog2(NUM_BITS + 1);
  // One timer serves both the SCLK half-period and the reset-pulse hold.
  localparam int TMAX = (HALF_DIV > RST_HOLD) ? HALF_DIV : RST_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HALF_LD = TW'(HALF_DIV - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(RST_HOLD - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_DRST
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] sh_q, sh_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                sdi_q, sdi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_done;
  logic                in_frame;

  assign tmr_done = (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_done ? tmr_q : tmr_q - TW'(1);
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (DRST_REQ) begin
          state_d = S_DRST;
          tmr_d   = HOLD_LD;
        end else if (START) begin
          state_d   = S_SETUP;
          tmr_d     = HALF_LD;
          sh_d      = CFG;
          bit_cnt_d = '0;
        end
      end
      S_SETUP: begin
        if (tmr_done) begin
          state_d = S_HIGH;
          tmr_d   = HALF_LD;
        end
      end
      S_HIGH: begin
        if (tmr_done) begin
          state_d   = S_LOW;
          tmr_d     = HALF_LD;
          bit_cnt_d = bit_cnt_q + BW'(1);
          // Zero fill: once every bit is out, SDI naturally returns to 0.
          sh_d      = {1'b0, sh_q[NUM_BITS-1:1]};
        end
      end
      S_LOW: begin
        if (tmr_done) begin
          state_d = (bit_cnt_q == LAST_BIT) ? S_LATCH : S_HIGH;
          tmr_d   = HALF_LD;
        end
      end
      S_LATCH: begin
        if (tmr_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_DRST: begin
        if (tmr_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pins are decoded from the next state so every output is a plain flop.
    in_frame = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
    cs_d     = ~in_frame;
    sclk_d   = (state_d == S_HIGH) || (state_d == S_DRST);
    sdi_d    = in_frame & sh_d[0];
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign CS   = cs_q;
  assign SCLK = sclk_q;
  assign SDI  = sdi_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_prog_spi_sequencer.sv
// Purpose: self-checking bench for prog_spi_sequencer; two instances (HALF_DIV 1 and 4)
//   driven by random and directed requests, checked against a pin-level programmer model.
// Latency/backpressure: expectations come from the frame/pulse timing rules, not the RTL.
module tb_prog_spi_sequencer;

  localparam int NB  = 111;
  localparam int RH  = 8;
  localparam int HD0 = 1;
  localparam int HD1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n  [2];
  logic          start  [2];
  logic          drst   [2];
  logic [NB-1:0] cfg_in [2];
  logic          busy   [2];
  logic          done   [2];
  logic          sdi    [2];
  logic          sclk   [2];
  logic          cs     [2];

  prog_spi_sequencer #(.NUM_BITS(NB), .HALF_DIV(HD0), .RST_HOLD(RH)) u_dut_fast (
    .CLK(clk), .RST_N(rst_n[0]), .START(start[0]), .CFG(cfg_in[0]), .DRST_REQ(drst[0]),
    .BUSY(busy[0]), .DONE(done[0]), .SDI(sdi[0]), .SCLK(sclk[0]), .CS(cs[0])
  );

  prog_spi_sequencer #(.NUM_BITS(NB), .HALF_DIV(HD1), .RST_HOLD(RH)) u_dut_slow (
    .CLK(clk), .RST_N(rst_n[1]), .START(start[1]), .CFG(cfg_in[1]), .DRST_REQ(drst[1]),
    .BUSY(busy[1]), .DONE(done[1]), .SDI(sdi[1]), .SCLK(sclk[1]), .CS(cs[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic int hd(input int i);
    return (i == 0) ? HD0 : HD1;
  endfunction

  // ---------------- programmer / pin model (sampled mid-cycle) ----------------
  logic [NB-1:0] prog     [2] = '{'0, '0};
  logic [NB-1:0] latched  [2] = '{'0, '0};
  int edges       [2] = '{0, 0};
  int latched_edg [2] = '{0, 0};
  int latch_cnt   [2] = '{0, 0};
  int csfall_cnt  [2] = '{0, 0};
  int done_cnt    [2] = '{0, 0};
  int viol        [2] = '{0, 0};
  int ho_cnt      [2] = '{0, 0};
  int dres_cyc    [2] = '{0, 0};
  int per_min     [2] = '{0, 0};
  int per_max     [2] = '{0, 0};
  int last_rise   [2] = '{0, 0};
  int hi_run      [2] = '{0, 0};
  int last_gap    [2] = '{0, 0};
  logic p_cs   [2] = '{1'b1, 1'b1};
  logic p_sclk [2] = '{1'b0, 1'b0};
  logic p_sdi  [2] = '{1'b0, 1'b0};
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (cs[i] && sdi[i]) ho_cnt[i]++;          // HO output of the programmer
      if (cs[i] && sclk[i]) dres_cyc[i]++;       // DRESET asserted (low)
      if (done[i]) done_cnt[i]++;
      if (sclk[i] && !p_sclk[i] && (cs[i] != p_cs[i])) viol[i]++;
      if (!cs[i] && p_cs[i] && sclk[i]) viol[i]++;
      if ((sdi[i] != p_sdi[i]) && sclk[i]) viol[i]++;
      if (!cs[i] && p_cs[i]) begin
        csfall_cnt[i]++;
        last_gap[i] = hi_run[i];
        edges[i]    = 0;
        prog[i]     = '0;
        per_min[i]  = 1 << 30;
        per_max[i]  = 0;
      end
      if (!cs[i] && sclk[i] && !p_sclk[i]) begin
        prog[i] = {sdi[i], prog[i][NB-1:1]};
        edges[i]++;
        if (edges[i] > 1) begin
          if (cyc - last_rise[i] < per_min[i]) per_min[i] = cyc - last_rise[i];
          if (cyc - last_rise[i] > per_max[i]) per_max[i] = cyc - last_rise[i];
        end
        last_rise[i] = cyc;
      end
      if (cs[i] && !p_cs[i]) begin
        latched[i]     = prog[i];
        latched_edg[i] = edges[i];
        latch_cnt[i]++;
        hi_run[i] = 0;
      end
      if (cs[i]) hi_run[i]++;
      p_cs[i]   = cs[i];
      p_sclk[i] = sclk[i];
      p_sdi[i]  = sdi[i];
    end
  end

  // ---------------- one request, checked against the timing rules ----------------
  task automatic run_op(input int i, input logic st, input logic dr,
                        input logic [NB-1:0] c, input bit now);
    int   lat, l0, dc0, d0, f0;
    logic b1;
    bit   is_rst;
    is_rst = dr;                                  // reset pulse wins over a load
    l0  = latch_cnt[i];
    dc0 = done_cnt[i];
    d0  = dres_cyc[i];
    f0  = csfall_cnt[i];
    if (!now) begin
      @(negedge clk); #1;
    end
    cfg_in[i] = c;
    start[i]  = st;
    drst[i]   = dr;
    lat = -1;
    b1  = 1'b0;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk); #1;
      if (n == 1) begin
        start[i] = 1'b0;
        drst[i]  = 1'b0;
        b1       = busy[i];
      end
      if (done[i]) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("latency_i%0d", i), lat, is_rst ? RH + 1 : (2 * NB + 2) * hd(i) + 1);
    chk($sformatf("busy_after_accept_i%0d", i), b1, 1'b1);
    chk($sformatf("busy_at_done_i%0d", i), busy[i], 1'b0);
    chk($sformatf("done_count_i%0d", i), done_cnt[i] - dc0, 1);
    if (is_rst) begin
      chk($sformatf("dreset_cycles_i%0d", i), dres_cyc[i] - d0, RH);
      chk($sformatf("no_cs_fall_i%0d", i), csfall_cnt[i] - f0, 0);
    end else begin
      chk($sformatf("latch_count_i%0d", i), latch_cnt[i] - l0, 1);
      chk($sformatf("frame_i%0d", i), latched[i], c);
      chk($sformatf("sclk_edges_i%0d", i), latched_edg[i], NB);
      chk($sformatf("sclk_per_min_i%0d", i), per_min[i], 2 * hd(i));
      chk($sformatf("sclk_per_max_i%0d", i), per_max[i], 2 * hd(i));
      chk($sformatf("no_dreset_i%0d", i), dres_cyc[i] - d0, 0);
    end
  endtask

  function automatic logic [NB-1:0] rnd_cfg();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[NB-1:0];
  endfunction

  initial begin
    logic [127:0]  w;
    logic [NB-1:0] pat;
    int            dc0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i]  = 1'b1;
      start[i]  = 1'b0;
      drst[i]   = 1'b0;
      cfg_in[i] = '0;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_pins_i%0d", i), {cs[i], sclk[i], sdi[i], busy[i], done[i]}, 5'b10000);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
    end

    // Directed load, HALF_DIV=1, 0x5A..A5 pattern.
    w = {16{8'h5A}};
    w[7:0] = 8'hA5;
    pat = w[NB-1:0];
    run_op(0, 1'b1, 1'b0, pat, 1'b0);

    // Directed load, HALF_DIV=4, all ones (HO must stay low through LATCH).
    run_op(1, 1'b1, 1'b0, '1, 1'b0);

    // Reset pulse, then START+DRST_REQ together.
    run_op(1, 1'b0, 1'b1, rnd_cfg(), 1'b0);
    run_op(0, 1'b1, 1'b1, rnd_cfg(), 1'b0);

    // Requests raised while BUSY are dropped.
    dc0 = 0;
    fork
      run_op(1, 1'b1, 1'b0, rnd_cfg(), 1'b0);
      begin
        repeat (40) begin
          @(negedge clk); #1;
        end
        start[1] = 1'b1;
        drst[1]  = 1'b1;
        @(negedge clk); #1;
        start[1] = 1'b0;
        drst[1]  = 1'b0;
      end
    join
    dc0 = done_cnt[1];
    repeat (30) begin
      @(negedge clk); #1;
    end
    chk("ignored_req_busy", busy[1], 1'b0);
    chk("ignored_req_done", done_cnt[1] - dc0, 0);

    // Async reset at bit 50, then a clean full load.
    @(negedge clk); #1;
    cfg_in[1] = rnd_cfg();
    start[1]  = 1'b1;
    @(negedge clk); #1;
    start[1]  = 1'b0;
    for (int n = 0; n < 2000 && edges[1] < 50; n++) begin
      @(negedge clk); #1;
    end
    chk("edges_before_rst", edges[1], 50);
    rst_n[1] = 1'b0;
    #1;
    chk("midframe_reset_pins", {cs[1], sclk[1], sdi[1], busy[1], done[1]}, 5'b10000);
    @(negedge clk); #1;
    rst_n[1] = 1'b1;
    @(negedge clk); #1;
    run_op(1, 1'b1, 1'b0, rnd_cfg(), 1'b0);

    // Back-to-back: second START in the DONE cycle.
    run_op(1, 1'b1, 1'b0, rnd_cfg(), 1'b0);
    run_op(1, 1'b1, 1'b0, rnd_cfg(), 1'b1);
    chk("b2b_cs_gap", last_gap[1] >= HD1 + 1, 1'b1);

    // Random mix of requests on both instances.
    for (int k = 0; k < 8; k++) begin
      int sel;
      int i;
      i   = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      run_op(i, sel != 1, sel == 1 || sel == 2, rnd_cfg(), 1'b0);
    end

    repeat (4) begin
      @(negedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pin_invariants_i%0d", i), viol[i], 0);
      chk($sformatf("ho_never_high_i%0d", i), ho_cnt[i], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
